// File: rtl/exe_mem_pipe_buffer.sv
// -----------------------------------------------------------------------------
// exe_mem_pipe_buffer
//
// Elastic EXE->MEM pipeline stage. It holds up to DEPTH retired EXE entries in a
// circular buffer, so EXE can keep retiring while MEM stalls on a data-memory or
// stack access. Transfers on both sides use a valid/ready handshake. A flush
// discards every buffered entry, and the current occupancy is reported on count.
//
// Parameters
//   DATA_W      width of alu_result / reg2_val
//   REG_ADDR_W  width of the destination register index
//   DEPTH       number of buffer entries (>= 1, any value, not only powers of 2)
//   CNT_W       width of count; must be able to hold the value DEPTH
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   flush               drop all buffered entries (branch/exception)
//   in_valid/in_ready   EXE-side handshake
//   *_in                EXE entry: control bits, alu result, store data, dest
//   out_valid/out_ready MEM-side handshake for the head entry
//   wb_en..dest         head entry, forced to 0 while the buffer is empty
//   count               current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module exe_mem_pipe_buffer #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  wb_en_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic                  push_en_in,
    input  logic                  pop_en_in,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic [DATA_W-1:0]     reg2_val_in,
    input  logic [REG_ADDR_W-1:0] dest_in,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  wb_en,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  push_en,
    output logic                  pop_en,
    output logic [DATA_W-1:0]     alu_result,
    output logic [DATA_W-1:0]     reg2_val,
    output logic [REG_ADDR_W-1:0] dest,

    output logic [CNT_W-1:0]      count
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               ENTRY_W  = 5 + 2 * DATA_W + REG_ADDR_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // One entry is kept as a single flat word:
    // {wb_en, mem_read, mem_write, push_en, pop_en, alu_result, reg2_val, dest}
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] head;

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;

    logic               do_accept;
    logic               do_release;

    // Pointers wrap explicitly at DEPTH-1 because DEPTH need not be a power of 2.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign in_entry = {wb_en_in, mem_read_in, mem_write_in, push_en_in, pop_en_in,
                       alu_result_in, reg2_val_in, dest_in};

    // in_ready is derived from the registered count only, so a full buffer
    // refuses input even when MEM is draining in the same cycle.
    assign in_ready   = (count_q < FULL_CNT);
    assign out_valid  = (count_q != '0);

    assign do_accept  = in_valid  & in_ready  & ~flush;
    assign do_release = out_valid & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            // NOTE: the storage is cleared on reset here on purpose, so no stale
            // payload survives a reset; flush below leaves it untouched because
            // empty-buffer outputs are gated to 0 anyway.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count_q <= '0;
            rd_ptr  <= wr_ptr;
        end else begin
            // NOTE: every register here uses <=, so the pointer and count updates
            // all see the pre-edge values and may be written in any order.
            if (do_accept) begin
                mem[wr_ptr] <= in_entry;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_release) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_accept, do_release})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload is gated with out_valid so MEM never sees stale control bits
    // (e.g. a leftover mem_write) while the buffer is empty.
    assign head = mem[rd_ptr] & {ENTRY_W{out_valid}};

    assign {wb_en, mem_read, mem_write, push_en, pop_en,
            alu_result, reg2_val, dest} = head;

    assign count = count_q;

endmodule
